// File: rtl/ycbcr422_packer.sv
// ycbcr422_packer: 4:4:4 to 4:2:2 packer with a 4-word output queue; define YCBCR422_CHROMA_AVG_EN for averaged chroma
module ycbcr422_packer #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_cb,
    input  logic [DW-1:0] in_cr,
    input  logic          in_eol,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_c,
    output logic          out_sel,
    output logic          out_eol
);
    typedef enum logic {EVEN, ODD} phase_t;
    localparam int WW = 2 * DW + 2;
    phase_t        phase;
    logic [DW-1:0] y0, cb0, cr0;
    logic [WW-1:0] q [4];
    logic [1:0]    rd, wr;
    logic [2:0]    count;
    logic          acc, push, pop, odd;
    logic [DW-1:0] cb_p, cr_p;
    logic [WW-1:0] w0, w1;
`ifdef YCBCR422_CHROMA_AVG_EN
    logic [DW:0]   cb_sum, cr_sum;
    // round-half-up average of the held even pixel and the current odd pixel
    always_comb begin
        cb_sum = {1'b0, cb0} + {1'b0, in_cb} + (DW+1)'(1);
        cr_sum = {1'b0, cr0} + {1'b0, in_cr} + (DW+1)'(1);
        cb_p   = cb_sum[DW:1];
        cr_p   = cr_sum[DW:1];
    end
`else
    assign cb_p = cb0;
    assign cr_p = cr0;
`endif
    // handshakes and the two words pushed for a completed pair or a lone end-of-line pixel
    always_comb begin
        in_ready  = !rst && count <= 3'd2;
        acc       = in_valid && in_ready;
        odd       = phase == ODD;
        push      = acc && (odd || in_eol);
        out_valid = count != 3'd0;
        pop       = out_valid && out_ready;
        w0        = {2'b00, odd ? cb_p : in_cb, odd ? y0 : in_y};
        w1        = {in_eol, 1'b1, odd ? cr_p : in_cr, in_y};
        {out_eol, out_sel, out_c, out_y} = out_valid ? q[rd] : '0;
    end
    // phase FSM, held even pixel and output queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= EVEN;
            y0    <= '0;
            cb0   <= '0;
            cr0   <= '0;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (acc && !odd && !in_eol) begin
                y0  <= in_y;
                cb0 <= in_cb;
                cr0 <= in_cr;
            end
            if (acc)
                phase <= (!odd && !in_eol) ? ODD : EVEN;
            if (push) begin
                q[wr]        <= w0;
                q[wr + 2'd1] <= w1;
                wr           <= wr + 2'd2;
            end
            if (pop)
                rd <= rd + 2'd1;
            count <= count + (push ? 3'd2 : 3'd0) - {2'b00, pop};
        end
    end
endmodule

// File: tb/tb_ycbcr422_packer.sv
// tb_ycbcr422_packer: table vectors, corner sequences and a randomized stream against a line-pairing model
module tb_ycbcr422_packer;
    localparam int DW = 10;
`ifdef YCBCR422_CHROMA_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    typedef logic [2*DW+1:0] word_t;
    typedef struct {logic [DW-1:0] y, cb, cr; logic eol;} pix_t;
    typedef struct {int y0, cb0, cr0, y1, cb1, cr1; bit eol; int c0_avg, c1_avg;} vec_t;

    logic clk, rst, in_valid, in_ready, in_eol, out_valid, out_ready, out_sel, out_eol;
    logic [DW-1:0] in_y, in_cb, in_cr, out_y, out_c;

    ycbcr422_packer #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_c(out_c), .out_sel(out_sel), .out_eol(out_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0, errors = 0, n_acc = 0;
    bit    rnd_rdy = 1'b0;
    word_t got_q[$], exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic word_t mkw(input int sel, input int c, input int y, input int eol);
        return {eol[0], sel[0], c[DW-1:0], y[DW-1:0]};
    endfunction

    function automatic pix_t pix(input int y, input int cb, input int cr, input int eol);
        pix_t p;
        p.y = y[DW-1:0]; p.cb = cb[DW-1:0]; p.cr = cr[DW-1:0]; p.eol = eol[0];
        return p;
    endfunction

    function automatic int chroma(input int a, input int b);
        return AVG ? (a + b + 1) / 2 : a;
    endfunction

    // expected words: each line is split into pixel pairs from its start; a leftover last pixel stands alone
    function automatic void model(input pix_t px[$]);
        int i = 0;
        exp_q.delete();
        while (i < px.size()) begin
            if (px[i].eol) begin
                exp_q.push_back(mkw(0, px[i].cb, px[i].y, 0));
                exp_q.push_back(mkw(1, px[i].cr, px[i].y, 1));
                i += 1;
            end else if (i + 1 < px.size()) begin
                exp_q.push_back(mkw(0, chroma(px[i].cb, px[i+1].cb), px[i].y, 0));
                exp_q.push_back(mkw(1, chroma(px[i].cr, px[i+1].cr), px[i+1].y, px[i+1].eol));
                i += 2;
            end else break;
        end
    endfunction

    task automatic drive(input pix_t px[$], input bit gaps);
        bit acc;
        int t;
        foreach (px[k]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_y = px[k].y; in_cb = px[k].cb; in_cr = px[k].cr; in_eol = px[k].eol;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 300) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            chk("pixel_accept", acc, 1);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int t = 0;
        got_q.delete();
        while (got_q.size() < n && t < budget) begin
            @(negedge clk);
            if (out_valid && out_ready) got_q.push_back({out_eol, out_sel, out_c, out_y});
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = $urandom_range(0, 2) != 0;
            t++;
        end
    endtask

    task automatic cmpq(input string name);
        word_t g;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[k]) begin
            g = 'x;
            if (k < got_q.size()) g = got_q[k];
            chk($sformatf("%s_w%0d", name, k), g, exp_q[k]);
        end
    endtask

    initial begin
        vec_t tbl[4];
        pix_t px[$];
        pix_t p;
        int   c0, c1;
        tbl[0] = '{100, 300, 500, 200, 401, 600, 1'b1, 351, 550};
        tbl[1] = '{1023, 1023, 1023, 0, 1022, 1023, 1'b0, 1023, 1023};
        tbl[2] = '{0, 0, 0, 1, 1, 0, 1'b1, 1, 0};
        tbl[3] = '{512, 2, 6, 7, 5, 3, 1'b0, 4, 5};

        rst = 1'b1; in_valid = 1'b1; in_y = 10'd77; in_cb = 10'd88; in_cr = 10'd99;
        in_eol = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_outputs", {out_valid, out_eol, out_sel, out_c, out_y}, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            c0 = AVG ? tbl[i].c0_avg : tbl[i].cb0;
            c1 = AVG ? tbl[i].c1_avg : tbl[i].cr0;
            in_valid = 1'b1; in_eol = 1'b0;
            in_y = DW'(tbl[i].y0); in_cb = DW'(tbl[i].cb0); in_cr = DW'(tbl[i].cr0);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_y = DW'(tbl[i].y1); in_cb = DW'(tbl[i].cb1); in_cr = DW'(tbl[i].cr1); in_eol = tbl[i].eol;
            @(negedge clk);
            chk($sformatf("vec%0d_even_no_push", i), out_valid, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_word0", i), {out_valid, out_eol, out_sel, out_c, out_y},
                {1'b1, mkw(0, c0, tbl[i].y0, 0)});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("vec%0d_word1", i), {out_valid, out_eol, out_sel, out_c, out_y},
                {1'b1, mkw(1, c1, tbl[i].y1, tbl[i].eol)});
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("vec%0d_empty", i), {out_valid, out_eol, out_sel, out_c, out_y}, 0);
            @(posedge clk); #1;
        end

        px = {pix(10, 40, 70, 0), pix(20, 50, 80, 0), pix(30, 60, 90, 1)};
        exp_q = {mkw(0, AVG ? 45 : 40, 10, 0), mkw(1, AVG ? 75 : 70, 20, 0),
                 mkw(0, 60, 30, 0), mkw(1, 90, 30, 1)};
        fork
            drive(px, 1'b0);
            collect(4, 50);
        join
        cmpq("oddline");

        px.delete();
        for (int i = 0; i < 8; i++) px.push_back(pix(100 + i, 37 * i, 1000 - 55 * i, 0));
        model(px);
        out_ready = 1'b0; n_acc = 0;
        fork
            drive(px, 1'b0);
            begin
                repeat (12) @(negedge clk);
                chk("bp_accepted", n_acc, 4);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_head", {out_valid, out_eol, out_sel, out_c, out_y}, {1'b1, exp_q[0]});
                @(posedge clk); #1;
                out_ready = 1'b1;
                collect(8, 200);
            end
        join
        chk("bp_all_accepted", n_acc, 8);
        cmpq("bp");

        out_ready = 1'b0;
        drive({pix(1, 2, 3, 0), pix(2, 4, 6, 0), pix(5, 500, 600, 0)}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_flushed", {out_valid, out_eol, out_sel, out_c, out_y}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        px = {pix(7, 11, 21, 0), pix(9, 13, 23, 1)};
        model(px);
        fork
            drive(px, 1'b0);
            collect(2, 50);
        join
        cmpq("rstmid");

        px.delete();
        for (int i = 0; i < 300; i++) begin
            p.y   = DW'($urandom_range(0, 1023));
            p.cb  = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 10'd1023 : 10'd0) : DW'($urandom_range(0, 1023));
            p.cr  = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 10'd1023 : 10'd0) : DW'($urandom_range(0, 1023));
            p.eol = (i == 299) || ($urandom_range(0, 5) == 0);
            px.push_back(p);
        end
        model(px);
        n_acc = 0; rnd_rdy = 1'b1;
        fork
            drive(px, 1'b1);
            collect(exp_q.size(), 20000);
        join
        rnd_rdy = 1'b0; out_ready = 1'b1;
        chk("rand_all_accepted", n_acc, 300);
        cmpq("rand");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rand_drained", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
